packet_demux_ts_nch: RTL and testbench
======================================

// Module: packet_demux_ts_nch
// PURPOSE
//  N-port AVST packet demultiplexer with SOP timestamp, per-port enable, drop-on-disabled and counters.
//  Sits after the RX MAC/PTP stage and feeds the per-channel RX queues; replaces the fixed 8-ch demux wrappers.
//  One registered output stage; the channel is locked at SOP for the whole packet.
// PARAMETERS
//  NUM_PORTS      8    output ports, 2..16
//  CHANNEL_WIDTH  3    i_avst_channel width, >= $clog2(NUM_PORTS)
//  DATA_WIDTH     128  AVST data width
//  EMPTY_WIDTH    4    AVST empty width
//  ERROR_WIDTH    6    AVST error width
//  TS_WIDTH       96   RX timestamp width
//  CNT_WIDTH      32   statistics counter width
// PORTS
//  clk                 in   1                       clock
//  rst                 in   1                       asynchronous reset, active-high
//  i_avst_ready        out  1                       upstream ready
//  i_avst_valid/_startofpacket/_endofpacket  in 1   upstream beat qualifiers
//  i_avst_channel      in   CHANNEL_WIDTH           destination port, sampled on SOP beat only
//  i_avst_error/_empty/_data  in  ERROR/EMPTY/DATA_WIDTH  beat payload
//  i_ts_data           in   TS_WIDTH                timestamp, sampled on the accepted SOP beat
//  i_port_enable       in   NUM_PORTS               per-port enable; disabled port => packet dropped
//  i_cnt_clear         in   1                       synchronous clear of all counters
//  o_avst_ready        in   NUM_PORTS               per-port downstream ready
//  o_avst_valid/_startofpacket/_endofpacket  out NUM_PORTS  per-port qualifiers
//  o_avst_error/_empty/_data  out  ERROR/EMPTY/DATA_WIDTH  shared payload bus, qualified by o_avst_valid[p]
//  o_ts_valid          out  NUM_PORTS               o_avst_valid[p] & o_avst_startofpacket[p]
//  o_ts_data           out  TS_WIDTH                timestamp of the packet held in the stage
//  o_pkt_cnt           out  NUM_PORTS*CNT_WIDTH     per-port delivered-packet count
//  o_drop_cnt          out  CNT_WIDTH               dropped-packet count
//  o_framing_err       out  1                       sticky: SOP inside a packet, or beat outside a packet
// BEHAVIOUR
//  Reset: stage_valid=0, all o_*valid=0, counters=0, o_framing_err=0, state IDLE. i_avst_ready=0 while rst is high.
//  Handshake: i_avst_ready = !rst & (!stage_valid | o_avst_ready[stage_port]). A beat transfers on valid&ready.
//  Latency: 1 cycle from input accept to o_avst_valid. Full throughput while the target port is ready.
//  Output: o_avst_valid[p] = stage_valid & (stage_port==p). Payload/ts are held stable until o_avst_ready[p].
//  FSM IDLE/FWD/DROP, advanced on accepted beats only:
//   IDLE + SOP: lock port=channel. Go to DROP if channel>=NUM_PORTS or !i_port_enable[channel], else FWD.
//    A single-beat packet (SOP&EOP) returns to IDLE.
//   FWD: beats go to the stage at the locked port. EOP -> IDLE.
//   DROP: beats are consumed and never staged. EOP -> IDLE and o_drop_cnt++.
//    A dropped beat is accepted even when stage_valid=1 if o_avst_ready[stage_port]=1; otherwise it waits.
//   IDLE + non-SOP beat: consumed, not staged, sets o_framing_err.
//   FWD/DROP + SOP: sets o_framing_err and re-locks as in IDLE. The truncated packet is not counted.
//  i_port_enable changes take effect at the next SOP; a packet already in progress is unaffected.
//  o_pkt_cnt[p]++ on an output handshake with EOP on port p.
//  Counters saturate at all-ones. i_cnt_clear has priority over a coincident increment (result 0).
//  i_avst_channel/i_ts_data on non-SOP beats are ignored. Reset mid-packet discards the stage and returns to IDLE.
// STRUCTURE
//  packet_demux_pkg: state enum, beat struct {sop,eop,error,empty,data}, port index type $clog2(NUM_PORTS).
//  Sub-module packet_demux_sat_cnt (CNT_WIDTH, inc, clr, saturating): NUM_PORTS+1 instances.
// TESTING
//  1. NUM_PORTS=8, 3-beat pkts to ch 0..7, all ready -> each port gets its pkt 1 cycle later, o_pkt_cnt[p]=1, ts match.
//  2. Port 5 ready low 4 cycles mid-packet -> i_avst_ready low 4 cycles, no beat lost or duplicated, payload stable.
//  3. i_port_enable[2]=0, 4-beat pkt to ch2, and ch=9 with NUM_PORTS=8 -> no o_avst_valid, o_drop_cnt=2.
//  4. SOP, then SOP again with no EOP -> o_framing_err=1, second pkt delivered intact, pkt count +1 only.
//  5. CNT_WIDTH=4, 20 pkts to port 0 -> o_pkt_cnt[0]=15; i_cnt_clear with a coincident EOP -> 0.
//  6. rst asserted asynchronously mid-packet -> all valids 0 immediately; next SOP after release forwards normally.

Source files
------------

// File: rtl/packet_demux_ts_nch_pkg.sv
// Shared types for the timestamped N-port AVST packet demultiplexer.
// Default widths match the standard 8-channel RX configuration.
package packet_demux_ts_nch_pkg;

  localparam int DEF_NUM_PORTS   = 8;
  localparam int DEF_DATA_WIDTH  = 128;
  localparam int DEF_EMPTY_WIDTH = 4;
  localparam int DEF_ERROR_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic                       sop;
    logic                       eop;
    logic [DEF_ERROR_WIDTH-1:0] error;
    logic [DEF_EMPTY_WIDTH-1:0] empty;
    logic [DEF_DATA_WIDTH-1:0]  data;
  } beat_t;

  typedef logic [$clog2(DEF_NUM_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/packet_demux_ts_nch_if.sv
// AVST handshake bundle: one upstream stream in, NUM_PORTS qualified streams out
// on a shared payload bus. slave = demux side, master = source/sink side.
interface packet_demux_ts_nch_if #(
  parameter int NUM_PORTS     = 8,
  parameter int CHANNEL_WIDTH = 3,
  parameter int DATA_WIDTH    = 128,
  parameter int EMPTY_WIDTH   = 4,
  parameter int ERROR_WIDTH   = 6
);
  logic                     i_avst_ready;
  logic                     i_avst_valid;
  logic                     i_avst_startofpacket;
  logic                     i_avst_endofpacket;
  logic [CHANNEL_WIDTH-1:0] i_avst_channel;
  logic [ERROR_WIDTH-1:0]   i_avst_error;
  logic [EMPTY_WIDTH-1:0]   i_avst_empty;
  logic [DATA_WIDTH-1:0]    i_avst_data;

  logic [NUM_PORTS-1:0]     o_avst_ready;
  logic [NUM_PORTS-1:0]     o_avst_valid;
  logic [NUM_PORTS-1:0]     o_avst_startofpacket;
  logic [NUM_PORTS-1:0]     o_avst_endofpacket;
  logic [ERROR_WIDTH-1:0]   o_avst_error;
  logic [EMPTY_WIDTH-1:0]   o_avst_empty;
  logic [DATA_WIDTH-1:0]    o_avst_data;

  modport slave (
    output i_avst_ready,
    input  i_avst_valid, i_avst_startofpacket, i_avst_endofpacket,
    input  i_avst_channel, i_avst_error, i_avst_empty, i_avst_data,
    input  o_avst_ready,
    output o_avst_valid, o_avst_startofpacket, o_avst_endofpacket,
    output o_avst_error, o_avst_empty, o_avst_data
  );

  modport master (
    input  i_avst_ready,
    output i_avst_valid, i_avst_startofpacket, i_avst_endofpacket,
    output i_avst_channel, i_avst_error, i_avst_empty, i_avst_data,
    output o_avst_ready,
    input  o_avst_valid, o_avst_startofpacket, o_avst_endofpacket,
    input  o_avst_error, o_avst_empty, o_avst_data
  );
endinterface

// File: rtl/packet_demux_ts_nch_sat_cnt.sv
// Saturating statistics counter; clear wins over a coincident increment.
module packet_demux_ts_nch_sat_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/packet_demux_ts_nch.sv
// N-port AVST demux with SOP timestamp capture, per-port enable/drop and stats.
// A single registered stage feeds a shared payload bus; the port is locked at SOP.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | between packets; next accepted beat should be SOP
//   FWD     | packet locked to an enabled port, beats go to the stage
//   DROP    | packet for a disabled/out-of-range port, beats consumed
module packet_demux_ts_nch
  import packet_demux_ts_nch_pkg::*;
#(
  parameter int NUM_PORTS     = 8,
  parameter int CHANNEL_WIDTH = 3,
  parameter int DATA_WIDTH    = 128,
  parameter int EMPTY_WIDTH   = 4,
  parameter int ERROR_WIDTH   = 6,
  parameter int TS_WIDTH      = 96,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  packet_demux_ts_nch_if.slave           avst,
  input  logic [TS_WIDTH-1:0]            i_ts_data,
  input  logic [NUM_PORTS-1:0]           i_port_enable,
  input  logic                           i_cnt_clear,
  output logic [NUM_PORTS-1:0]           o_ts_valid,
  output logic [TS_WIDTH-1:0]            o_ts_data,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] o_pkt_cnt,
  output logic [CNT_WIDTH-1:0]           o_drop_cnt,
  output logic                           o_framing_err
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [ERROR_WIDTH-1:0] error;
    logic [EMPTY_WIDTH-1:0] empty;
    logic [DATA_WIDTH-1:0]  data;
  } stage_t;

  state_t               state;
  logic [PW-1:0]        lock_port;
  logic [PW-1:0]        stage_port;
  logic                 stage_valid;
  stage_t               stage;
  logic [TS_WIDTH-1:0]  ts_q;
  logic                 framing_err;

  logic                 in_ready;
  logic                 accept;
  logic                 out_fire;
  logic [PW-1:0]        ch_idx;
  logic                 ch_ok;
  logic                 drop_inc;
  stage_t               in_beat;
  logic [NUM_PORTS-1:0] port_valid;
  logic [NUM_PORTS-1:0] pkt_inc;

  always_comb begin
    in_ready = !rst && (!stage_valid || avst.o_avst_ready[stage_port]);
    accept   = avst.i_avst_valid && in_ready;
    out_fire = stage_valid && avst.o_avst_ready[stage_port];
    ch_idx   = avst.i_avst_channel[PW-1:0];
    // Range check on the full channel value before trusting the enable bit
    ch_ok    = (32'(avst.i_avst_channel) < 32'(NUM_PORTS)) ? i_port_enable[ch_idx] : 1'b0;
    in_beat  = '{sop:   avst.i_avst_startofpacket,
                 eop:   avst.i_avst_endofpacket,
                 error: avst.i_avst_error,
                 empty: avst.i_avst_empty,
                 data:  avst.i_avst_data};
    drop_inc = accept && avst.i_avst_endofpacket &&
               ((avst.i_avst_startofpacket && !ch_ok) ||
                (!avst.i_avst_startofpacket && (state == ST_DROP)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      lock_port   <= '0;
      stage_port  <= '0;
      stage_valid <= 1'b0;
      stage       <= '0;
      ts_q        <= '0;
      framing_err <= 1'b0;
    end else begin
      if (out_fire) begin
        stage_valid <= 1'b0;
      end
      if (accept) begin
        if (avst.i_avst_startofpacket) begin
          if (state != ST_IDLE) begin
            framing_err <= 1'b1;
          end
          lock_port <= ch_idx;
          if (ch_ok) begin
            stage_valid <= 1'b1;
            stage_port  <= ch_idx;
            stage       <= in_beat;
            ts_q        <= i_ts_data;
            state       <= avst.i_avst_endofpacket ? ST_IDLE : ST_FWD;
          end else begin
            state       <= avst.i_avst_endofpacket ? ST_IDLE : ST_DROP;
          end
        end else begin
          case (state)
            ST_FWD: begin
              stage_valid <= 1'b1;
              stage_port  <= lock_port;
              stage       <= in_beat;
              if (avst.i_avst_endofpacket) begin
                state <= ST_IDLE;
              end
            end
            ST_DROP: begin
              if (avst.i_avst_endofpacket) begin
                state <= ST_IDLE;
              end
            end
            default: begin
              framing_err <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_valid[p] = stage_valid && (stage_port == PW'(p));
    end
    pkt_inc = port_valid & avst.o_avst_ready & {NUM_PORTS{stage.eop}};
  end

  assign avst.i_avst_ready         = in_ready;
  assign avst.o_avst_valid         = port_valid;
  assign avst.o_avst_startofpacket = port_valid & {NUM_PORTS{stage.sop}};
  assign avst.o_avst_endofpacket   = port_valid & {NUM_PORTS{stage.eop}};
  assign avst.o_avst_error         = stage.error;
  assign avst.o_avst_empty         = stage.empty;
  assign avst.o_avst_data          = stage.data;
  assign o_ts_valid                = port_valid & {NUM_PORTS{stage.sop}};
  assign o_ts_data                 = ts_q;
  assign o_framing_err             = framing_err;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pkt_cnt
    packet_demux_ts_nch_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
      .clk (clk),
      .rst (rst),
      .clr (i_cnt_clear),
      .inc (pkt_inc[p]),
      .q   (o_pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  packet_demux_ts_nch_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (i_cnt_clear),
    .inc (drop_inc),
    .q   (o_drop_cnt)
  );

endmodule

// File: tb/tb_packet_demux_ts_nch.sv
// Directed bench for packet_demux_ts_nch: forwarding, backpressure, drops,
// framing errors, counter saturation/clear and asynchronous reset.
module tb_packet_demux_ts_nch;

  localparam int N    = 8;
  localparam int CW   = 4;
  localparam int DW   = 128;
  localparam int EW   = 4;
  localparam int ERW  = 6;
  localparam int TW   = 96;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [TW-1:0]     ts_data;
  logic [N-1:0]      port_enable;
  logic              cnt_clear;
  logic [N-1:0]      ts_valid;
  logic [TW-1:0]     ts_out;
  logic [N*CNTW-1:0] pkt_cnt;
  logic [CNTW-1:0]   drop_cnt;
  logic              framing_err;

  packet_demux_ts_nch_if #(.NUM_PORTS(N), .CHANNEL_WIDTH(CW), .DATA_WIDTH(DW),
                           .EMPTY_WIDTH(EW), .ERROR_WIDTH(ERW)) bus ();

  packet_demux_ts_nch #(.NUM_PORTS(N), .CHANNEL_WIDTH(CW), .DATA_WIDTH(DW),
                        .EMPTY_WIDTH(EW), .ERROR_WIDTH(ERW), .TS_WIDTH(TW),
                        .CNT_WIDTH(CNTW)) dut (
    .clk           (clk),
    .rst           (rst),
    .avst          (bus),
    .i_ts_data     (ts_data),
    .i_port_enable (port_enable),
    .i_cnt_clear   (cnt_clear),
    .o_ts_valid    (ts_valid),
    .o_ts_data     (ts_out),
    .o_pkt_cnt     (pkt_cnt),
    .o_drop_cnt    (drop_cnt),
    .o_framing_err (framing_err)
  );

  typedef struct packed {
    logic [3:0]     port;
    logic           sop;
    logic           eop;
    logic [ERW-1:0] err;
    logic [DW-1:0]  data;
    logic [TW-1:0]  ts;
  } rec_t;

  rec_t log_q[$];
  rec_t mon_r;
  int   any_valid_cnt = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc++;

  // Handshakes are logged mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (bus.o_avst_valid != '0) any_valid_cnt++;
    if (!rst) begin
      for (int p = 0; p < N; p++) begin
        if (bus.o_avst_valid[p] && bus.o_avst_ready[p]) begin
          mon_r.port = 4'(p);
          mon_r.sop  = bus.o_avst_startofpacket[p];
          mon_r.eop  = bus.o_avst_endofpacket[p];
          mon_r.err  = bus.o_avst_error;
          mon_r.data = bus.o_avst_data;
          mon_r.ts   = ts_out;
          log_q.push_back(mon_r);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mkd(input int ch, input int b);
    return DW'(32'h1000 * (ch + 1) + b) | (DW'(32'hA5C3) << 100);
  endfunction

  function automatic logic [TW-1:0] mkts(input int ch);
    return TW'(32'h5000 + ch) | (TW'(1) << 90);
  endfunction

  function automatic rec_t mkrec(input int port, input logic sop, input logic eop,
                                 input logic [DW-1:0] d, input logic [TW-1:0] ts);
    rec_t r;
    r.port = 4'(port);
    r.sop  = sop;
    r.eop  = eop;
    r.err  = d[ERW-1:0];
    r.data = d;
    r.ts   = ts;
    return r;
  endfunction

  function automatic logic [CNTW-1:0] pc(input int p);
    return pkt_cnt[p*CNTW +: CNTW];
  endfunction

  task automatic send(input logic sop, input logic eop, input logic [CW-1:0] ch,
                      input logic [DW-1:0] d, input logic [TW-1:0] ts);
    int n;
    bus.i_avst_valid         = 1'b1;
    bus.i_avst_startofpacket = sop;
    bus.i_avst_endofpacket   = eop;
    bus.i_avst_channel       = ch;
    bus.i_avst_data          = d;
    bus.i_avst_error         = d[ERW-1:0];
    bus.i_avst_empty         = d[EW-1:0];
    ts_data                  = ts;
    n = 0;
    @(negedge clk);
    while (!bus.i_avst_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL send_timeout: ch=%0d ready never rose within %0d cycles", ch, n);
    end
    @(posedge clk);
    #1;
    bus.i_avst_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus.i_avst_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", bus.i_avst_ready);
    end
    total++;
    if (bus.o_avst_valid !== '0 || ts_valid !== '0) begin
      bad++; $display("FAIL reset_valid: got %h/%h want 0", bus.o_avst_valid, ts_valid);
    end
    total++;
    if (pkt_cnt !== '0 || drop_cnt !== '0 || framing_err !== 1'b0) begin
      bad++; $display("FAIL reset_stats: pkt=%h drop=%h ferr=%b want 0", pkt_cnt, drop_cnt, framing_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.i_avst_ready !== 1'b1) begin
      bad++; $display("FAIL release_ready: got %b want 1", bus.i_avst_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ports();
    int start, base;
    rec_t exp;
    base  = log_q.size();
    start = cyc;
    for (int ch = 0; ch < N; ch++) begin
      for (int b = 0; b < 3; b++) begin
        send(b == 0, b == 2, CW'(ch), mkd(ch, b), mkts(ch));
        if (b == 0) begin
          total++;
          if (bus.o_avst_valid !== N'(1 << ch) || ts_valid !== N'(1 << ch) ||
              ts_out !== mkts(ch) || bus.o_avst_data !== mkd(ch, 0)) begin
            bad++;
            $display("FAIL sop_latency ch%0d: valid=%h tsv=%h ts=%h data=%h want valid=%h ts=%h data=%h",
                     ch, bus.o_avst_valid, ts_valid, ts_out, bus.o_avst_data,
                     N'(1 << ch), mkts(ch), mkd(ch, 0));
          end
        end
      end
    end
    total++;
    if (cyc - start != 24) begin
      bad++; $display("FAIL throughput: 24 beats took %0d cycles want 24", cyc - start);
    end
    drain();
    total++;
    if (log_q.size() != base + 24) begin
      bad++; $display("FAIL fwd_count: got %0d beats want 24", log_q.size() - base);
    end else begin
      for (int i = 0; i < 24; i++) begin
        exp = mkrec(i / 3, (i % 3) == 0, (i % 3) == 2, mkd(i / 3, i % 3), mkts(i / 3));
        total++;
        if (log_q[base + i] !== exp) begin
          bad++; $display("FAIL fwd_beat%0d: got %h want %h", i, log_q[base + i], exp);
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      total++;
      if (pc(p) !== CNTW'(1)) begin
        bad++; $display("FAIL pkt_cnt%0d: got %0d want 1", p, pc(p));
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    rec_t exp;
    base = log_q.size();
    send(1'b1, 1'b0, CW'(5), mkd(5, 0), mkts(5));
    bus.o_avst_ready[5]      = 1'b0;
    bus.i_avst_valid         = 1'b1;
    bus.i_avst_startofpacket = 1'b0;
    bus.i_avst_endofpacket   = 1'b0;
    bus.i_avst_data          = mkd(5, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.i_avst_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready cyc%0d: got %b want 0", i, bus.i_avst_ready);
      end
      total++;
      if (bus.o_avst_valid !== 8'h20 || bus.o_avst_data !== mkd(5, 0)) begin
        bad++; $display("FAIL bp_hold cyc%0d: valid=%h data=%h want 20/%h",
                        i, bus.o_avst_valid, bus.o_avst_data, mkd(5, 0));
      end
      @(posedge clk);
      #1;
    end
    bus.o_avst_ready[5] = 1'b1;
    send(1'b0, 1'b0, CW'(5), mkd(5, 1), mkts(5));
    send(1'b0, 1'b1, CW'(5), mkd(5, 2), mkts(5));
    drain();
    total++;
    if (log_q.size() != base + 3) begin
      bad++; $display("FAIL bp_count: got %0d beats want 3", log_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp = mkrec(5, i == 0, i == 2, mkd(5, i), mkts(5));
        total++;
        if (log_q[base + i] !== exp) begin
          bad++; $display("FAIL bp_beat%0d: got %h want %h", i, log_q[base + i], exp);
        end
      end
    end
    total++;
    if (pc(5) !== CNTW'(2)) begin
      bad++; $display("FAIL bp_pkt_cnt5: got %0d want 2", pc(5));
    end
  endtask

  task automatic test_drop();
    int base, av;
    base = log_q.size();
    av   = any_valid_cnt;
    port_enable[2] = 1'b0;
    for (int b = 0; b < 4; b++) send(b == 0, b == 3, CW'(2), mkd(2, b + 8), mkts(2));
    send(1'b1, 1'b0, CW'(9), mkd(9, 0), mkts(9));
    send(1'b0, 1'b1, CW'(9), mkd(9, 1), mkts(9));
    drain();
    port_enable = '1;
    total++;
    if (log_q.size() != base || any_valid_cnt != av) begin
      bad++; $display("FAIL drop_leak: beats=%0d valid_cycles=%0d want 0/0",
                      log_q.size() - base, any_valid_cnt - av);
    end
    total++;
    if (drop_cnt !== CNTW'(2)) begin
      bad++; $display("FAIL drop_cnt: got %0d want 2", drop_cnt);
    end
    total++;
    if (framing_err !== 1'b0) begin
      bad++; $display("FAIL drop_ferr: got %b want 0", framing_err);
    end
  endtask

  task automatic test_framing();
    int base;
    rec_t exp;
    base = log_q.size();
    send(1'b1, 1'b0, CW'(1), mkd(1, 7), TW'(32'h111));
    send(1'b1, 1'b0, CW'(3), mkd(3, 4), TW'(32'h333));
    send(1'b0, 1'b0, CW'(3), mkd(3, 5), TW'(32'h999));
    send(1'b0, 1'b1, CW'(3), mkd(3, 6), TW'(32'h999));
    drain();
    total++;
    if (framing_err !== 1'b1) begin
      bad++; $display("FAIL ferr_set: got %b want 1", framing_err);
    end
    total++;
    if (log_q.size() != base + 4) begin
      bad++; $display("FAIL ferr_count: got %0d beats want 4", log_q.size() - base);
    end else begin
      exp = mkrec(1, 1'b1, 1'b0, mkd(1, 7), TW'(32'h111));
      total++;
      if (log_q[base] !== exp) begin
        bad++; $display("FAIL ferr_trunc: got %h want %h", log_q[base], exp);
      end
      for (int i = 0; i < 3; i++) begin
        exp = mkrec(3, i == 0, i == 2, mkd(3, 4 + i), TW'(32'h333));
        total++;
        if (log_q[base + 1 + i] !== exp) begin
          bad++; $display("FAIL ferr_beat%0d: got %h want %h", i, log_q[base + 1 + i], exp);
        end
      end
    end
    total++;
    if (pc(1) !== CNTW'(1) || pc(3) !== CNTW'(2)) begin
      bad++; $display("FAIL ferr_pkt_cnt: p1=%0d p3=%0d want 1/2", pc(1), pc(3));
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 20; k++) send(1'b1, 1'b1, CW'(0), mkd(0, k), mkts(0));
    drain();
    total++;
    if (pc(0) !== CNTW'(15)) begin
      bad++; $display("FAIL sat_cnt0: got %0d want 15", pc(0));
    end
    send(1'b1, 1'b1, CW'(0), mkd(0, 30), mkts(0));
    cnt_clear = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_avst_valid[0] !== 1'b1 || bus.o_avst_endofpacket[0] !== 1'b1) begin
      bad++; $display("FAIL clr_eop_present: valid=%b eop=%b want 1/1",
                      bus.o_avst_valid[0], bus.o_avst_endofpacket[0]);
    end
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    @(negedge clk);
    total++;
    if (pkt_cnt !== '0 || drop_cnt !== '0) begin
      bad++; $display("FAIL clr_priority: pkt=%h drop=%0d want 0/0", pkt_cnt, drop_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int base;
    rec_t exp;
    bus.o_avst_ready[4] = 1'b0;
    send(1'b1, 1'b0, CW'(4), mkd(4, 0), mkts(4));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_avst_valid !== '0 || ts_valid !== '0 || bus.i_avst_ready !== 1'b0) begin
      bad++; $display("FAIL async_rst: valid=%h tsv=%h ready=%b want 0/0/0",
                      bus.o_avst_valid, ts_valid, bus.i_avst_ready);
    end
    total++;
    if (framing_err !== 1'b0) begin
      bad++; $display("FAIL async_rst_ferr: got %b want 0", framing_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.o_avst_ready = '1;
    base = log_q.size();
    send(1'b1, 1'b0, CW'(6), mkd(6, 0), mkts(6));
    send(1'b0, 1'b1, CW'(6), mkd(6, 1), mkts(1));
    drain();
    total++;
    if (log_q.size() != base + 2) begin
      bad++; $display("FAIL post_rst_count: got %0d beats want 2", log_q.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp = mkrec(6, i == 0, i == 1, mkd(6, i), mkts(6));
        total++;
        if (log_q[base + i] !== exp) begin
          bad++; $display("FAIL post_rst_beat%0d: got %h want %h", i, log_q[base + i], exp);
        end
      end
    end
    total++;
    if (pc(6) !== CNTW'(1) || framing_err !== 1'b0) begin
      bad++; $display("FAIL post_rst_stats: p6=%0d ferr=%b want 1/0", pc(6), framing_err);
    end
  endtask

  initial begin
    bus.i_avst_valid         = 1'b0;
    bus.i_avst_startofpacket = 1'b0;
    bus.i_avst_endofpacket   = 1'b0;
    bus.i_avst_channel       = '0;
    bus.i_avst_error         = '0;
    bus.i_avst_empty         = '0;
    bus.i_avst_data          = '0;
    bus.o_avst_ready         = '1;
    ts_data                  = '0;
    port_enable              = '1;
    cnt_clear                = 1'b0;
    test_reset();
    test_all_ports();
    test_backpressure();
    test_drop();
    test_framing();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
